gpr_wb_arbiter: RTL and testbench

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_wb_arbiter.sv | 114 +++++++++++
 tb/tb_gpr_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: merges pipeline WB writes with long-latency (mul/div) results
// through a small in-order buffer, with WAW invalidation and pending-write stall detection.
module gpr_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_rw,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rw,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  output logic        rf_wr_en,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_data,
  output logic        stall_pending,
  output logic [2:0]  occupancy,
  output logic [15:0] lu_block_cnt
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  // Buffer is kept compacted: valid entries occupy slots 0..occupancy-1, oldest in slot 0.
  logic [DEPTH-1:0] vld_q, vld_nxt;
  logic [4:0]       rw_q   [DEPTH];
  logic [4:0]       rw_nxt [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [31:0]      data_nxt [DEPTH];

  logic pipe_wr, deq, bypass, enq;

  assign occupancy = 3'($countones(vld_q));
  assign lu_ready  = occupancy < DEPTH_L;
  assign pipe_wr   = pipe_wr_en && (pipe_rw != 5'd0);
  assign deq       = !pipe_wr && vld_q[0];
  assign bypass    = !pipe_wr && !vld_q[0] && lu_valid && (lu_rw != 5'd0);
  assign enq       = lu_valid && lu_ready && (lu_rw != 5'd0) && !bypass &&
                     !(pipe_wr && (lu_rw == pipe_rw));

  always_comb begin
    rf_wr_en = 1'b0;
    rf_rw    = 5'd0;
    rf_data  = 32'd0;
    if (pipe_wr) begin
      rf_wr_en = 1'b1;
      rf_rw    = pipe_rw;
      rf_data  = pipe_data;
    end else if (deq) begin
      rf_wr_en = 1'b1;
      rf_rw    = rw_q[0];
      rf_data  = data_q[0];
    end else if (bypass) begin
      rf_wr_en = 1'b1;
      rf_rw    = lu_rw;
      rf_data  = lu_data;
    end
  end

  always_comb begin
    stall_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (((rs_id != 5'd0) && (rs_id == rw_q[i])) ||
                       ((rt_id != 5'd0) && (rt_id == rw_q[i]))))
        stall_pending = 1'b1;
    end
  end

  // Survivors (not dequeued, not WAW-killed) slide down in order; a new result lands after them.
  always_comb begin
    int slot;
    slot    = 0;
    vld_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rw_nxt[i]   = rw_q[i];
      data_nxt[i] = data_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(deq && i == 0) && !(pipe_wr && (rw_q[i] == pipe_rw))) begin
        vld_nxt[slot]  = 1'b1;
        rw_nxt[slot]   = rw_q[i];
        data_nxt[slot] = data_q[i];
        slot++;
      end
    end
    if (enq && slot < DEPTH) begin
      vld_nxt[slot]  = 1'b1;
      rw_nxt[slot]   = lu_rw;
      data_nxt[slot] = lu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_nxt;
  end

  // NOTE: payload storage has no reset; it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    rw_q   <= rw_nxt;
    data_q <= data_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lu_block_cnt <= 16'd0;
    else if (lu_valid && !lu_ready && (lu_block_cnt != 16'hFFFF))
      lu_block_cnt <= lu_block_cnt + 16'd1;
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios plus randomized traffic checked against a
// queue-based model of the arbitration, WAW and saturation rules.
module tb_gpr_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wr_en, lu_valid;
  logic [4:0]  pipe_rw, lu_rw, rs_id, rt_id;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, rf_wr_en, stall_pending;
  logic [4:0]  rf_rw;
  logic [31:0] rf_data;
  logic [2:0]  occupancy;
  logic [15:0] lu_block_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_cnt = 0;

  gpr_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_wr_en(pipe_wr_en), .pipe_rw(pipe_rw), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rw(lu_rw), .lu_data(lu_data), .lu_ready(lu_ready),
    .rs_id(rs_id), .rt_id(rt_id),
    .rf_wr_en(rf_wr_en), .rf_rw(rf_rw), .rf_data(rf_data),
    .stall_pending(stall_pending), .occupancy(occupancy), .lu_block_cnt(lu_block_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    pipe_wr_en = 1'b0; pipe_rw = 5'd0; pipe_data = 32'd0;
    lu_valid   = 1'b0; lu_rw   = 5'd0; lu_data   = 32'd0;
    rs_id      = 5'd0; rt_id   = 5'd0;
  endtask

  // Model advance at the clock edge, from the inputs presented during the cycle.
  task automatic model_step();
    bit   pw, ready, deq, byp;
    ent_t nq[$];
    pw    = pipe_wr_en && pipe_rw != 5'd0;
    ready = mq.size() < DEPTH;
    deq   = !pw && mq.size() > 0;
    byp   = !pw && mq.size() == 0 && lu_valid && lu_rw != 5'd0;
    if (lu_valid && !ready && m_cnt < 65535) m_cnt++;
    for (int i = 0; i < mq.size(); i++) begin
      if (deq && i == 0) continue;
      if (pw && mq[i].rw == pipe_rw) continue;
      nq.push_back(mq[i]);
    end
    if (lu_valid && ready && lu_rw != 5'd0 && !byp && !(pw && lu_rw == pipe_rw))
      nq.push_back(ent_t'{lu_rw, lu_data});
    mq = nq;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    mq.delete();
    m_cnt = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", lu_ready); end
    total++; if (lu_block_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0h want=0", lu_block_cnt); end
    total++; if (stall_pending !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_pending); end
    pipe_wr_en = 1'b1; pipe_rw = 5'd4; pipe_data = 32'hCAFE0004;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd4, 32'hCAFE0004}) begin
      bad++; $display("FAIL reset_pipe_write got=%b/%0d/%h want=1/4/cafe0004", rf_wr_en, rf_rw, rf_data); end
    set_idle();
    lu_valid = 1'b1; lu_rw = 5'd6; lu_data = 32'h0BAD0006;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd6, 32'h0BAD0006}) begin
      bad++; $display("FAIL reset_bypass got=%b/%0d/%h want=1/6/0bad0006", rf_wr_en, rf_rw, rf_data); end
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_simultaneous();
    set_idle();
    pipe_wr_en = 1'b1; pipe_rw = 5'd5; pipe_data = 32'hAAAA0000;
    lu_valid   = 1'b1; lu_rw   = 5'd7; lu_data   = 32'h12345678;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd5, 32'hAAAA0000}) begin
      bad++; $display("FAIL sim_pipe_first got=%b/%0d/%h want=1/5/aaaa0000", rf_wr_en, rf_rw, rf_data); end
    cycle();
    set_idle();
    #1;
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL sim_enq_occ got=%0d want=1", occupancy); end
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd7, 32'h12345678}) begin
      bad++; $display("FAIL sim_drain got=%b/%0d/%h want=1/7/12345678", rf_wr_en, rf_rw, rf_data); end
    cycle();
    total++; if (occupancy !== 3'd0 || rf_wr_en !== 1'b0) begin
      bad++; $display("FAIL sim_empty got=occ%0d/en%b want=occ0/en0", occupancy, rf_wr_en); end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    set_idle();
    pipe_wr_en = 1'b1; pipe_rw = 5'd1; pipe_data = 32'h11;
    lu_valid = 1'b1; lu_rw = 5'd2; lu_data = 32'hA0000002;
    cycle();
    lu_rw = 5'd3; lu_data = 32'hB0000003;
    cycle();
    lu_rw = 5'd4; lu_data = 32'hC0000004;
    #1;
    c0 = lu_block_cnt;
    total++; if (lu_ready !== 1'b0 || occupancy !== 3'd2) begin
      bad++; $display("FAIL bp_full got=ready%b/occ%0d want=ready0/occ2", lu_ready, occupancy); end
    cycle();
    total++; if (lu_block_cnt !== c0 + 16'd1) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", lu_block_cnt, c0 + 16'd1); end
    pipe_wr_en = 1'b0;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd2, 32'hA0000002} || lu_ready !== 1'b0) begin
      bad++; $display("FAIL bp_drain1 got=%b/%0d/%h/ready%b want=1/2/a0000002/ready0", rf_wr_en, rf_rw, rf_data, lu_ready); end
    cycle();
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd3, 32'hB0000003} || lu_ready !== 1'b1) begin
      bad++; $display("FAIL bp_drain2 got=%b/%0d/%h/ready%b want=1/3/b0000003/ready1", rf_wr_en, rf_rw, rf_data, lu_ready); end
    cycle();
    lu_valid = 1'b0;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd4, 32'hC0000004} || occupancy !== 3'd1) begin
      bad++; $display("FAIL bp_third got=%b/%0d/%h/occ%0d want=1/4/c0000004/occ1", rf_wr_en, rf_rw, rf_data, occupancy); end
    cycle();
    total++; if (occupancy !== 3'd0 || lu_block_cnt !== c0 + 16'd2) begin
      bad++; $display("FAIL bp_end got=occ%0d/cnt%0d want=occ0/cnt%0d", occupancy, lu_block_cnt, c0 + 16'd2); end
  endtask

  task automatic test_waw();
    set_idle();
    pipe_wr_en = 1'b1; pipe_rw = 5'd1; pipe_data = 32'h1;
    lu_valid = 1'b1; lu_rw = 5'd9; lu_data = 32'h99999999;
    cycle();
    lu_valid = 1'b0;
    rs_id = 5'd9;
    #1;
    total++; if (stall_pending !== 1'b1) begin bad++; $display("FAIL waw_stall_rs got=%b want=1", stall_pending); end
    rs_id = 5'd0; rt_id = 5'd9;
    #1;
    total++; if (stall_pending !== 1'b1) begin bad++; $display("FAIL waw_stall_rt got=%b want=1", stall_pending); end
    rt_id = 5'd8;
    #1;
    total++; if (stall_pending !== 1'b0) begin bad++; $display("FAIL waw_nostall got=%b want=0", stall_pending); end
    rs_id = 5'd9; rt_id = 5'd0;
    pipe_rw = 5'd9; pipe_data = 32'h0000F009;
    lu_valid = 1'b1; lu_rw = 5'd9; lu_data = 32'hDEAD0009;
    cycle();
    set_idle();
    rs_id = 5'd9;
    #1;
    total++; if (occupancy !== 3'd0 || stall_pending !== 1'b0) begin
      bad++; $display("FAIL waw_kill got=occ%0d/stall%b want=occ0/stall0", occupancy, stall_pending); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL waw_no_lu_write got=%b/%0d want=0", rf_wr_en, rf_rw); end
      cycle();
    end
  endtask

  task automatic test_zero_reg();
    set_idle();
    lu_valid = 1'b1; lu_rw = 5'd0; lu_data = 32'h5A5A5A5A;
    #1;
    total++; if (lu_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
      bad++; $display("FAIL zero_lu got=ready%b/en%b want=ready1/en0", lu_ready, rf_wr_en); end
    cycle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL zero_lu_occ got=%0d want=0", occupancy); end
    pipe_wr_en = 1'b1; pipe_rw = 5'd0; pipe_data = 32'h77;
    lu_rw = 5'd5; lu_data = 32'h00000055;
    #1;
    total++; if ({rf_wr_en, rf_rw, rf_data} !== {1'b1, 5'd5, 32'h00000055}) begin
      bad++; $display("FAIL zero_pipe_bypass got=%b/%0d/%h want=1/5/00000055", rf_wr_en, rf_rw, rf_data); end
    cycle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL zero_bypass_occ got=%0d want=0", occupancy); end
    set_idle();
    cycle();
  endtask

  task automatic test_reset_mid();
    set_idle();
    pipe_wr_en = 1'b1; pipe_rw = 5'd1;
    lu_valid = 1'b1; lu_rw = 5'd2; lu_data = 32'h22;
    cycle();
    lu_rw = 5'd3; lu_data = 32'h33;
    cycle();
    set_idle();
    #2;
    total++; if (occupancy !== 3'd2 || lu_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_full got=occ%0d/ready%b want=occ2/ready0", occupancy, lu_ready); end
    reset = 1'b0;
    mq.delete();
    m_cnt = 0;
    #1;
    total++; if (occupancy !== 3'd0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_async got=occ%0d/ready%b want=occ0/ready1", occupancy, lu_ready); end
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_no_write got=%b/%0d want=0", rf_wr_en, rf_rw); end
    end
  endtask

  task automatic test_random();
    bit   pw, ready, e_en;
    logic [4:0]  e_rw;
    logic [31:0] e_data;
    bit   e_stall;
    for (int n = 0; n < 400; n++) begin
      pipe_wr_en = ($urandom_range(0, 99) < 40);
      pipe_rw    = 5'($urandom_range(0, 7));
      pipe_data  = $urandom;
      lu_valid   = ($urandom_range(0, 99) < 60);
      lu_rw      = 5'($urandom_range(0, 7));
      lu_data    = $urandom;
      rs_id      = 5'($urandom_range(0, 7));
      rt_id      = 5'($urandom_range(0, 7));
      #1;
      pw    = pipe_wr_en && pipe_rw != 5'd0;
      ready = mq.size() < DEPTH;
      e_en = 1'b0; e_rw = 5'd0; e_data = 32'd0;
      if (pw)                                  begin e_en = 1; e_rw = pipe_rw;  e_data = pipe_data;  end
      else if (mq.size() > 0)                  begin e_en = 1; e_rw = mq[0].rw; e_data = mq[0].data; end
      else if (lu_valid && lu_rw != 5'd0)      begin e_en = 1; e_rw = lu_rw;    e_data = lu_data;    end
      e_stall = 1'b0;
      foreach (mq[i])
        if ((rs_id != 0 && rs_id == mq[i].rw) || (rt_id != 0 && rt_id == mq[i].rw)) e_stall = 1'b1;
      total++; if (rf_wr_en !== e_en || (e_en && (rf_rw !== e_rw || rf_data !== e_data))) begin
        bad++; $display("FAIL rnd_write n=%0d got=%b/%0d/%h want=%b/%0d/%h", n, rf_wr_en, rf_rw, rf_data, e_en, e_rw, e_data); end
      total++; if (lu_ready !== ready || occupancy !== 3'(mq.size())) begin
        bad++; $display("FAIL rnd_buf n=%0d got=ready%b/occ%0d want=ready%b/occ%0d", n, lu_ready, occupancy, ready, mq.size()); end
      total++; if (stall_pending !== e_stall || lu_block_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rnd_misc n=%0d got=stall%b/cnt%0d want=stall%b/cnt%0d", n, stall_pending, lu_block_cnt, e_stall, m_cnt); end
      cycle();
    end
    set_idle();
  endtask

  task automatic test_saturate();
    set_idle();
    pulse_reset();
    pipe_wr_en = 1'b1; pipe_rw = 5'd1;
    lu_valid = 1'b1; lu_rw = 5'd2;
    cycle();
    lu_rw = 5'd3;
    cycle();
    lu_rw = 5'd4;
    repeat (65534) cycle();
    total++; if (lu_block_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", lu_block_cnt); end
    repeat (10) cycle();
    total++; if (lu_block_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=ffff", lu_block_cnt); end
    repeat (4400) cycle();
    total++; if (lu_block_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", lu_block_cnt); end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_simultaneous();
    test_backpressure();
    test_waw();
    test_zero_reg();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
